// File: rtl/bpred_gshare_assoc_if.sv
// Fetch/EX port bundle for the gshare predictor with set-associative BTB.
// BPRED_RAS_EN adds the predecode call/return strobes.
interface bpred_gshare_assoc_if #(
    parameter int GHR_WIDTH = 10
);
    logic                 ready;
    logic                 fetch_valid;
    logic [31:0]          fetch_pc;
    logic                 fetch_hit;
    logic                 fetch_taken;
    logic [31:0]          fetch_target;
    logic [GHR_WIDTH-1:0] fetch_ghr;
    logic                 ex_valid;
    logic [31:0]          ex_pc;
    logic                 ex_taken;
    logic [31:0]          ex_target;
    logic [GHR_WIDTH-1:0] ex_ghr;
    logic                 ex_mispredict;
`ifdef BPRED_RAS_EN
    logic                 fetch_is_call;
    logic                 fetch_is_ret;

    modport master (
        input  ready, fetch_hit, fetch_taken,
        input  fetch_target, fetch_ghr,
        output fetch_valid, fetch_pc,
        output fetch_is_call, fetch_is_ret,
        output ex_valid, ex_pc, ex_taken,
        output ex_target, ex_ghr, ex_mispredict
    );

    modport slave (
        output ready, fetch_hit, fetch_taken,
        output fetch_target, fetch_ghr,
        input  fetch_valid, fetch_pc,
        input  fetch_is_call, fetch_is_ret,
        input  ex_valid, ex_pc, ex_taken,
        input  ex_target, ex_ghr, ex_mispredict
    );
`else
    modport master (
        input  ready, fetch_hit, fetch_taken,
        input  fetch_target, fetch_ghr,
        output fetch_valid, fetch_pc,
        output ex_valid, ex_pc, ex_taken,
        output ex_target, ex_ghr, ex_mispredict
    );

    modport slave (
        output ready, fetch_hit, fetch_taken,
        output fetch_target, fetch_ghr,
        input  fetch_valid, fetch_pc,
        input  ex_valid, ex_pc, ex_taken,
        input  ex_target, ex_ghr, ex_mispredict
    );
`endif
endinterface

// File: rtl/bpred_gshare_assoc.sv
// Gshare predictor with N-way round-robin BTB and speculative GHR.
// Optional return-address stack enabled by BPRED_RAS_EN.
module bpred_gshare_assoc #(
    parameter int BTB_ENTRIES = 128,
    parameter int BTB_WAYS    = 2,
    parameter int PHT_ENTRIES = 1024,
    parameter int GHR_WIDTH   = $clog2(PHT_ENTRIES),
    parameter int RAS_DEPTH   = 8
) (
    input logic clk,
    input logic rst,
    bpred_gshare_assoc_if.slave bp
);
    localparam int SETS = BTB_ENTRIES / BTB_WAYS;
    localparam int S    = $clog2(SETS);
    localparam int TW   = 30 - S;
    localparam int WW   = (BTB_WAYS > 1) ? $clog2(BTB_WAYS) : 1;
    localparam int NI   = (PHT_ENTRIES > SETS) ? PHT_ENTRIES : SETS;
    localparam int IW   = $clog2(NI);

    typedef enum logic {INIT, RUN} state_t;

    state_t               state;
    logic [IW-1:0]        init_idx;
    logic                 ready;
    logic [GHR_WIDTH-1:0] ghr;

    logic [1:0]          pht   [PHT_ENTRIES];
    logic [BTB_WAYS-1:0] vld   [SETS];
    logic [TW-1:0]       tag_q [SETS][BTB_WAYS];
    logic [31:0]         tgt_q [SETS][BTB_WAYS];
    logic [WW-1:0]       rr    [SETS];

    logic [S-1:0]         f_set;
    logic [TW-1:0]        f_tag;
    logic [GHR_WIDTH-1:0] f_idx;
    logic                 f_hit;
    logic [WW-1:0]        f_way;

    logic [S-1:0]         e_set;
    logic [TW-1:0]        e_tag;
    logic [GHR_WIDTH-1:0] e_idx;
    logic                 e_hit;
    logic [WW-1:0]        e_way;
    logic                 e_inv;
    logic [WW-1:0]        e_iway;
    logic [WW-1:0]        a_way;
    logic [1:0]           e_cnt;
    logic [1:0]           e_cnt_next;
    logic                 ex_en;

    logic                 pred_hit;
    logic                 pred_taken;
    logic [31:0]          pred_tgt;

    logic                 unused;

    assign unused = ^{bp.fetch_pc[1:0], bp.ex_pc[1:0]};

    assign f_set = bp.fetch_pc[S+1:2];
    assign f_tag = bp.fetch_pc[31:S+2];
    assign f_idx = bp.fetch_pc[GHR_WIDTH+1:2] ^ ghr;

    assign e_set = bp.ex_pc[S+1:2];
    assign e_tag = bp.ex_pc[31:S+2];
    assign e_idx = bp.ex_pc[GHR_WIDTH+1:2] ^ bp.ex_ghr;
    assign ex_en = ready & bp.ex_valid;

    always_comb begin
        f_hit = 1'b0;
        f_way = '0;
        for (int w = 0; w < BTB_WAYS; w++) begin
            if (!f_hit && vld[f_set][w] &&
                tag_q[f_set][w] == f_tag) begin
                f_hit = 1'b1;
                f_way = WW'(w);
            end
        end
    end

    always_comb begin
        e_hit  = 1'b0;
        e_way  = '0;
        e_inv  = 1'b0;
        e_iway = '0;
        for (int w = 0; w < BTB_WAYS; w++) begin
            if (!e_hit && vld[e_set][w] &&
                tag_q[e_set][w] == e_tag) begin
                e_hit = 1'b1;
                e_way = WW'(w);
            end
            if (!e_inv && !vld[e_set][w]) begin
                e_inv  = 1'b1;
                e_iway = WW'(w);
            end
        end
    end

    assign a_way = e_inv ? e_iway : rr[e_set];
    assign e_cnt = pht[e_idx];

    always_comb begin
        e_cnt_next = e_cnt;
        if (bp.ex_taken) begin
            if (e_cnt != 2'b11)
                e_cnt_next = e_cnt + 2'b01;
        end else begin
            if (e_cnt != 2'b00)
                e_cnt_next = e_cnt - 2'b01;
        end
    end

`ifdef BPRED_RAS_EN
    localparam int RW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CW = $clog2(RAS_DEPTH + 1);

    logic [31:0]   ras [RAS_DEPTH];
    logic [RW-1:0] sp;
    logic [CW-1:0] cnt;
    logic [RW-1:0] sp_dec;
    logic [RW-1:0] sp_pop;
    logic [RW-1:0] sp_push;
    logic          ras_pop;
    logic          ras_push;

    assign sp_dec   = (sp == '0) ? RW'(RAS_DEPTH - 1) : sp - 1'b1;
    assign ras_pop  = bp.fetch_valid & bp.fetch_is_ret & (cnt != '0);
    assign ras_push = bp.fetch_valid & bp.fetch_is_call;
    assign sp_pop   = ras_pop ? sp_dec : sp;
    assign sp_push  = (sp_pop == RW'(RAS_DEPTH - 1)) ? '0
                                                     : sp_pop + 1'b1;

    // Pop happens before push, so a call+return pair replaces the top.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sp  <= '0;
            cnt <= '0;
        end else if (ready) begin
            if (ras_push) begin
                ras[sp_pop] <= bp.fetch_pc + 32'd4;
                sp          <= sp_push;
                if (!ras_pop && cnt != CW'(RAS_DEPTH))
                    cnt <= cnt + 1'b1;
            end else if (ras_pop) begin
                sp  <= sp_dec;
                cnt <= cnt - 1'b1;
            end
        end
    end
`else
    localparam int unused_ras_depth = RAS_DEPTH;
`endif

    always_comb begin
        pred_hit   = f_hit;
        pred_taken = f_hit & pht[f_idx][1];
        pred_tgt   = tgt_q[f_set][f_way];
`ifdef BPRED_RAS_EN
        if (ras_pop) begin
            pred_hit   = 1'b1;
            pred_taken = 1'b1;
            pred_tgt   = ras[sp_dec];
        end
`endif
    end

    assign bp.ready        = ready;
    assign bp.fetch_hit    = ready ? pred_hit : 1'b0;
    assign bp.fetch_taken  = ready ? pred_taken : 1'b0;
    assign bp.fetch_target = ready ? pred_tgt : 32'd0;
    assign bp.fetch_ghr    = ready ? ghr : '0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= INIT;
            init_idx <= '0;
            ready    <= 1'b0;
            ghr      <= '0;
        end else begin
            unique case (state)
                INIT: begin
                    if (init_idx == IW'(NI - 1)) begin
                        state <= RUN;
                        ready <= 1'b1;
                    end else begin
                        init_idx <= init_idx + 1'b1;
                    end
                end
                RUN: ;
                default: state <= INIT;
            endcase
            // EX repair wins over the speculative fetch shift.
            if (ready) begin
                if (bp.ex_valid && bp.ex_mispredict)
                    ghr <= {bp.ex_ghr[GHR_WIDTH-2:0], bp.ex_taken};
                else if (bp.fetch_valid && pred_hit)
                    ghr <= {ghr[GHR_WIDTH-2:0], pred_taken};
            end
        end
    end

    // Table storage has no reset; the INIT sweep clears it.
    always_ff @(posedge clk) begin
        if (rst && state == INIT) begin
            if (32'(init_idx) < PHT_ENTRIES)
                pht[init_idx[GHR_WIDTH-1:0]] <= 2'b01;
            if (32'(init_idx) < SETS) begin
                vld[init_idx[S-1:0]] <= '0;
                rr[init_idx[S-1:0]]  <= '0;
            end
        end else if (rst && ex_en) begin
            pht[e_idx] <= e_cnt_next;
            if (bp.ex_taken) begin
                if (e_hit) begin
                    tgt_q[e_set][e_way] <= bp.ex_target;
                end else begin
                    vld[e_set][a_way]   <= 1'b1;
                    tag_q[e_set][a_way] <= e_tag;
                    tgt_q[e_set][a_way] <= bp.ex_target;
                    if (!e_inv)
                        rr[e_set] <= (BTB_WAYS > 1) ? rr[e_set] + 1'b1
                                                    : '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_bpred_gshare_assoc.sv
// Directed bench for bpred_gshare_assoc (default 2-way, 1024-entry PHT).
// Exercises the return stack too when built with BPRED_RAS_EN.
module tb_bpred_gshare_assoc;
    localparam int GW = 10;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    int   n;

    bpred_gshare_assoc_if #(.GHR_WIDTH(GW)) bp();

    bpred_gshare_assoc #(
        .BTB_ENTRIES(128),
        .BTB_WAYS(2),
        .PHT_ENTRIES(1024),
        .GHR_WIDTH(GW),
        .RAS_DEPTH(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bp(bp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ex_op(input logic [31:0] pc, input logic t,
                         input logic [31:0] tg,
                         input logic [GW-1:0] g, input logic m);
        bp.ex_valid      = 1'b1;
        bp.ex_pc         = pc;
        bp.ex_taken      = t;
        bp.ex_target     = tg;
        bp.ex_ghr        = g;
        bp.ex_mispredict = m;
        step();
        bp.ex_valid      = 1'b0;
        bp.ex_mispredict = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b0;
        bp.fetch_valid   = 1'b0;
        bp.fetch_pc      = '0;
        bp.ex_valid      = 1'b0;
        bp.ex_pc         = '0;
        bp.ex_taken      = 1'b0;
        bp.ex_target     = '0;
        bp.ex_ghr        = '0;
        bp.ex_mispredict = 1'b0;
`ifdef BPRED_RAS_EN
        bp.fetch_is_call = 1'b0;
        bp.fetch_is_ret  = 1'b0;
`endif
        step();
        step();
        bp.fetch_pc = 32'h100;
        #1;
        check("rst_ready", bp.ready, 0);
        check("rst_hit", bp.fetch_hit, 0);
        check("rst_target", bp.fetch_target, 0);

        // Updates during init must be dropped.
        rst = 1'b1;
        bp.ex_valid      = 1'b1;
        bp.ex_pc         = 32'h100;
        bp.ex_taken      = 1'b1;
        bp.ex_target     = 32'h999;
        bp.ex_ghr        = 10'd5;
        bp.ex_mispredict = 1'b1;
        n = 0;
        while (!bp.ready && n < 2000) begin
            step();
            n++;
            if (n == 10) begin
                check("init_hit", bp.fetch_hit, 0);
                check("init_ghr", bp.fetch_ghr, 0);
            end
        end
        check("init_len", n, 1024);
        bp.ex_valid      = 1'b0;
        bp.ex_mispredict = 1'b0;
        #1;
        check("run_ready", bp.ready, 1);
        check("init_ex_ignored", bp.fetch_hit, 0);
        check("run_ghr0", bp.fetch_ghr, 0);

        ex_op(32'h100, 1'b1, 32'h400, 10'd0, 1'b0);
        #1;
        check("alloc_hit", bp.fetch_hit, 1);
        check("alloc_target", bp.fetch_target, 32'h400);
        check("alloc_taken", bp.fetch_taken, 1);

        repeat (4) ex_op(32'h100, 1'b0, 32'h0, 10'd0, 1'b0);
        #1;
        check("sat_taken", bp.fetch_taken, 0);
        check("nt_keeps_btb", bp.fetch_target, 32'h400);
        ex_op(32'h100, 1'b1, 32'h400, 10'd0, 1'b0);
        #1;
        check("sat_up1", bp.fetch_taken, 0);
        ex_op(32'h100, 1'b1, 32'h480, 10'd0, 1'b0);
        #1;
        check("sat_up2", bp.fetch_taken, 1);
        check("retarget", bp.fetch_target, 32'h480);

        ex_op(32'h1014, 1'b1, 32'hA00, 10'd0, 1'b0);
        ex_op(32'h2014, 1'b1, 32'hB00, 10'd0, 1'b0);
        ex_op(32'h3014, 1'b1, 32'hC00, 10'd0, 1'b0);
        bp.fetch_pc = 32'h1014;
        #1;
        check("evict_a", bp.fetch_hit, 0);
        bp.fetch_pc = 32'h2014;
        #1;
        check("keep_b", bp.fetch_target, 32'hB00);
        bp.fetch_pc = 32'h3014;
        #1;
        check("keep_c", bp.fetch_target, 32'hC00);
        ex_op(32'h4014, 1'b1, 32'hD00, 10'd0, 1'b0);
        bp.fetch_pc = 32'h2014;
        #1;
        check("evict_b", bp.fetch_hit, 0);
        bp.fetch_pc = 32'h3014;
        #1;
        check("keep_c2", bp.fetch_hit, 1);
        bp.fetch_pc = 32'h4014;
        #1;
        check("keep_d", bp.fetch_target, 32'hD00);

        ex_op(32'h100, 1'b1, 32'h480, 10'd1, 1'b0);
        ex_op(32'h100, 1'b1, 32'h480, 10'd3, 1'b0);
        bp.fetch_pc    = 32'h100;
        bp.fetch_valid = 1'b1;
        #1;
        check("ghr_s0", bp.fetch_ghr, 0);
        check("ghr_t0", bp.fetch_taken, 1);
        step();
        check("ghr_s1", bp.fetch_ghr, 1);
        check("ghr_t1", bp.fetch_taken, 1);
        step();
        check("ghr_s2", bp.fetch_ghr, 3);
        check("ghr_t2", bp.fetch_taken, 1);
        step();
        bp.fetch_valid = 1'b0;
        #1;
        check("ghr_s3", bp.fetch_ghr, 7);

        bp.fetch_valid = 1'b1;
        ex_op(32'h800, 1'b0, 32'h0, 10'd5, 1'b1);
        bp.fetch_valid = 1'b0;
        #1;
        check("ghr_repair", bp.fetch_ghr, 10);

        bp.ex_valid  = 1'b1;
        bp.ex_pc     = 32'h100;
        bp.ex_taken  = 1'b1;
        bp.ex_target = 32'h480;
        bp.ex_ghr    = 10'd10;
        #1;
        check("rbw_old", bp.fetch_taken, 0);
        step();
        bp.ex_valid = 1'b0;
        #1;
        check("rbw_new", bp.fetch_taken, 1);

`ifdef BPRED_RAS_EN
        bp.fetch_valid   = 1'b1;
        bp.fetch_is_call = 1'b1;
        bp.fetch_pc      = 32'h200;
        step();
        bp.fetch_is_call = 1'b0;
        bp.fetch_is_ret  = 1'b1;
        bp.fetch_pc      = 32'h300;
        #1;
        check("ras_hit", bp.fetch_hit, 1);
        check("ras_taken", bp.fetch_taken, 1);
        check("ras_target", bp.fetch_target, 32'h204);
        step();
        bp.fetch_is_ret  = 1'b0;
        bp.fetch_is_call = 1'b1;
        for (int k = 0; k < 9; k++) begin
            bp.fetch_pc = 32'h1000 + 32'(16 * k);
            step();
        end
        bp.fetch_is_call = 1'b0;
        bp.fetch_is_ret  = 1'b1;
        bp.fetch_pc      = 32'h300;
        for (int k = 8; k >= 1; k--) begin
            #1;
            check("ras_lifo", bp.fetch_target,
                  32'h1004 + 32'(16 * k));
            step();
        end
        #1;
        check("ras_empty", bp.fetch_hit, 0);
        bp.fetch_is_ret = 1'b0;
        bp.fetch_valid  = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/bpred_gshare_assoc.md
Name: bpred_gshare_assoc

Overview:
Next-generation gshare branch predictor for the fetch/EX pipeline. It replaces a direct-mapped BTB with a parametrised N-way set-associative BTB using per-set round-robin replacement. The global history register is updated speculatively at fetch and repaired from an EX-supplied snapshot on mispredict. After reset, a multi-cycle init sweep clears the tables; fetch consults the predictor combinationally and EX updates it one branch per cycle.

Parameters:
BTB_ENTRIES, 128, total BTB entries; power of 2, multiple of BTB_WAYS
BTB_WAYS, 2, associativity; power of 2, 1..8
PHT_ENTRIES, 1024, 2-bit counters; power of 2
GHR_WIDTH, $clog2(PHT_ENTRIES), history length; also the PHT index width
RAS_DEPTH, 8, return-stack entries; used only with BPRED_RAS_EN

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-low reset
ready  out  1  init sweep finished; predictor active
fetch_valid  in  1  fetch_pc is a real fetch this cycle
fetch_pc  in  32  fetch address
fetch_hit  out  1  BTB tag match in some way of the set
fetch_taken  out  1  predict taken; redirect to fetch_target
fetch_target  out  32  predicted target
fetch_ghr  out  GHR_WIDTH  GHR value used for this prediction; pipelined to EX
ex_valid  in  1  resolved conditional or unconditional branch at EX
ex_pc  in  32  branch PC
ex_taken  in  1  resolved direction
ex_target  in  32  resolved target
ex_ghr  in  GHR_WIDTH  fetch_ghr snapshot travelling with this branch
ex_mispredict  in  1  direction or target mispredicted; qualified by ex_valid

Behaviour:
- Reset: rst is synchronous and active-low (clk). rst=0 → state INIT, sweep index 0, ghr=0, ready=0, RAS pointer=0. While ready=0, fetch_hit, fetch_taken, fetch_target and fetch_ghr are 0, and all ex_* inputs are ignored. Asserting rst in any state restarts INIT.
- FSM INIT: one index per cycle, 0..max(PHT_ENTRIES, SETS)-1.
  - PHT[i]=2'b01 (weak not-taken).
  - All BTB valid bits in set i cleared; rr_ptr[i]=0.
  - Last index written → RUN; ready=1 from the next cycle.
- FSM RUN: terminal until reset.
- Indexing:
  - SETS=BTB_ENTRIES/BTB_WAYS; S=$clog2(SETS).
  - set = pc[S+1:2]; tag = pc[31:S+2].
  - Fetch PHT index = fetch_pc[GHR_WIDTH+1:2] ^ ghr.
  - EX PHT index = ex_pc[GHR_WIDTH+1:2] ^ ex_ghr.
- Counter encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T. Predict taken iff bit[1]=1. Update saturates: +1 if ex_taken, -1 otherwise.
- Fetch, combinational, same cycle:
  - fetch_hit = any way valid with tag match; lowest matching way wins.
  - fetch_target = that way's target.
  - fetch_taken = fetch_hit & counter[1].
- Speculative GHR:
  - If ready & fetch_valid & fetch_hit, ghr <= {ghr[GHR_WIDTH-2:0], fetch_taken}.
  - fetch_ghr = ghr before the shift.
- EX update (ready & ex_valid), writes land at the clock edge:
  - PHT[ex index] always updated.
  - BTB hit and ex_taken → target overwritten with ex_target.
  - BTB hit and not taken → BTB unchanged.
  - BTB miss and ex_taken → allocate: lowest invalid way, else way rr_ptr[set], then rr_ptr[set] increments modulo BTB_WAYS. New entry: valid=1, tag, target.
  - BTB miss and not taken → no allocation.
- Mispredict (ex_valid & ex_mispredict):
  - ghr <= {ex_ghr[GHR_WIDTH-2:0], ex_taken}.
  - Overrides any fetch-side GHR shift in the same cycle.
- Same-cycle fetch and EX to the same PHT/BTB entry: fetch sees pre-update contents (read-before-write); no bypass.
- BTB_WAYS=1 degenerates to direct-mapped; rr_ptr is unused and held at 0.

Optional Feature:
Macro BPRED_RAS_EN.
- Defined, adds ports:
  - fetch_is_call  in  1
  - fetch_is_ret  in  1
  - Both come from predecode and are qualified by fetch_valid.
- Call: push fetch_pc+4 onto a circular RAS_DEPTH stack. When full, overwrite the oldest entry; count saturates at RAS_DEPTH.
- Return with RAS non-empty: fetch_hit=1, fetch_taken=1, fetch_target=top, then pop. RAS overrides the BTB/PHT prediction; the GHR shifts with taken=1.
- Return with RAS empty: normal BTB/PHT prediction.
- Call and return in the same cycle: pop first, then push.
- RAS is not repaired on mispredict.
- Not defined: ports, stack and logic are absent; RAS_DEPTH is ignored.

Test Plan:
- Init: rst=0 for 2 cycles, then 1 → ready=0 for exactly max(PHT_ENTRIES,SETS) cycles, then 1. Fetch outputs are 0 and ex updates are ignored throughout.
- Allocate/predict: ex_valid, ex_pc=0x100, taken, target=0x400, ex_ghr=0. Next cycle, fetch 0x100 with ghr=0 → hit=1, target=0x400, taken=1 (counter 01→10).
- Saturation: 4 not-taken updates at the same index → counter=00. One taken update → 01; fetch_taken stays 0.
- Replacement (BTB_WAYS=2): taken branches to one set, tags A, B, C → C evicts A (rr_ptr=0). A later fetch of A misses; B and C hit.
- GHR repair: three taken fetch hits shift ghr to 0b111. Then ex_mispredict with ex_ghr=0b0101 and ex_taken=0, plus a simultaneous fetch hit → ghr=0b1010.
- RAS (BPRED_RAS_EN): call at 0x200, then return → fetch_target=0x204, taken=1. Pushes at RAS_DEPTH+1 distinct PCs → the oldest is lost; pops return in LIFO order.
